// File: rtl/sensor_link_pkg.sv
// sensor_link_pkg: state encoding, default parameters and helpers for the sensor link sequencer.
package sensor_link_pkg;
   localparam int LINK_STATE_W = 4;
   localparam int DEF_D = 4;
   localparam int DEF_SETTLE_CYC = 1024;
   localparam int DEF_TRAIN_TIMEOUT = 4194304;
   localparam int DEF_LOSS_CYC = 16;
   localparam int DEF_MAX_RETRY = 3;
   localparam int DEF_BACKOFF_CYC = 4096;
   typedef enum logic [LINK_STATE_W-1:0] {
      S_IDLE = 4'd0, S_WAIT_RDY = 4'd1, S_SETTLE = 4'd2, S_START = 4'd3,
      S_TRAIN = 4'd4, S_CHECK = 4'd5, S_RETRY = 4'd6, S_BACKOFF = 4'd7,
      S_ARMED = 4'd8, S_STREAM = 4'd9, S_FAIL = 4'd10
   } link_state_e;
   function automatic int max3(input int a, input int b, input int c);
      return a > b ? (a > c ? a : c) : (b > c ? b : c);
   endfunction
endpackage

// File: rtl/link_cycle_timer.sv
// link_cycle_timer: down-counter reloaded while load is high; done marks the last cycle of a run.
module link_cycle_timer #(
   parameter int W = 8
) (
   input  logic         px_clk,
   input  logic         px_reset,
   input  logic         load,
   input  logic [W-1:0] val,
   output logic         done
);
   logic [W-1:0] cnt;
   always_ff @(posedge px_clk)
      if (px_reset) cnt <= '0;
      else if (load) cnt <= val;
      else if (cnt != '0) cnt <= cnt - W'(1);
   assign done = !load && cnt == '0;
endmodule

// File: rtl/sensor_link_ctrl.sv
// sensor_link_ctrl: LVDS sensor link bring-up sequencer with bounded retry and lock supervision.
// Define LINK_AUTO_RETRAIN_EN to retrain automatically on lock loss instead of failing.
module sensor_link_ctrl
   import sensor_link_pkg::*;
#(
   parameter int D             = DEF_D,
   parameter int SETTLE_CYC    = DEF_SETTLE_CYC,
   parameter int TRAIN_TIMEOUT = DEF_TRAIN_TIMEOUT,
   parameter int LOSS_CYC      = DEF_LOSS_CYC,
   parameter int MAX_RETRY     = DEF_MAX_RETRY,
   parameter int BACKOFF_CYC   = DEF_BACKOFF_CYC
) (
   input  logic                    px_clk,
   input  logic                    px_reset,
   input  logic                    enable,
   input  logic                    idelay_rdy,
   input  logic                    stream_req,
   input  logic [D-1:0]            train_lock,
   input  logic [D-1:0]            train_done,
   input  logic                    sen_vs_in,
   output logic                    train_start,
   output logic                    stream_on_out,
   output logic                    link_up,
   output logic                    link_fail,
   output logic [7:0]              retry_cnt,
   output logic [LINK_STATE_W-1:0] state_out
);
   localparam int TW = $clog2(max3(SETTLE_CYC, TRAIN_TIMEOUT, BACKOFF_CYC) + 1);
   localparam int LW = $clog2(LOSS_CYC + 1);
   link_state_e state;
   logic [TW-1:0] tmr_val;
   logic [LW-1:0] loss_cnt;
   logic tmr_run, tmr_done, vs_q, all_lock, all_done, abort;
   assign all_lock = &train_lock;
   assign all_done = &train_done;
   assign state_out = state;
   assign tmr_run = state inside {S_SETTLE, S_TRAIN, S_BACKOFF};
   // The timer is preloaded in the state preceding each timed state.
   always_comb tmr_val = state == S_WAIT_RDY ? TW'(SETTLE_CYC - 1) :
                         state == S_START    ? TW'(TRAIN_TIMEOUT - 1) : TW'(BACKOFF_CYC - 1);
   assign abort = !enable || (!idelay_rdy && !(state inside {S_IDLE, S_WAIT_RDY, S_FAIL}));
   link_cycle_timer #(.W(TW)) u_timer (
      .px_clk(px_clk), .px_reset(px_reset), .load(!tmr_run), .val(tmr_val), .done(tmr_done)
   );
   always_ff @(posedge px_clk) begin
      if (px_reset) begin
         state <= S_IDLE;
         train_start <= 1'b0;
         stream_on_out <= 1'b0;
         link_up <= 1'b0;
         link_fail <= 1'b0;
         retry_cnt <= '0;
         loss_cnt <= '0;
         vs_q <= 1'b0;
      end else begin
         vs_q <= sen_vs_in;
         train_start <= 1'b0;
         loss_cnt <= '0;
         if (abort) begin
            state <= S_IDLE;
            stream_on_out <= 1'b0;
            link_up <= 1'b0;
            retry_cnt <= '0;
         end else begin
            case (state)
               S_IDLE: state <= S_WAIT_RDY;
               S_WAIT_RDY: if (idelay_rdy) state <= S_SETTLE;
               S_SETTLE: if (tmr_done) begin
                  state <= S_START;
                  train_start <= 1'b1;
                  link_fail <= 1'b0;
                  retry_cnt <= '0;
               end
               S_START: state <= S_TRAIN;
               S_TRAIN: if (all_done) state <= S_CHECK; else if (tmr_done) state <= S_RETRY;
               S_CHECK: state <= all_lock ? S_ARMED : S_RETRY;
               S_RETRY: if (retry_cnt < 8'(MAX_RETRY)) begin
                  retry_cnt <= retry_cnt + 8'd1;
                  state <= S_BACKOFF;
               end else begin
                  link_fail <= 1'b1;
                  state <= S_FAIL;
               end
               S_BACKOFF: if (tmr_done) begin
                  state <= S_START;
                  train_start <= 1'b1;
               end
               S_ARMED: if (stream_req && vs_q && !sen_vs_in) begin
                  state <= S_STREAM;
                  stream_on_out <= 1'b1;
                  link_up <= 1'b1;
               end
               S_STREAM: if (!stream_req) begin
                  state <= S_ARMED;
                  stream_on_out <= 1'b0;
                  link_up <= 1'b0;
               end else if (!all_lock && loss_cnt == LW'(LOSS_CYC - 1)) begin
                  stream_on_out <= 1'b0;
                  link_up <= 1'b0;
`ifdef LINK_AUTO_RETRAIN_EN
                  retry_cnt <= '0;
                  state <= S_BACKOFF;
`else
                  link_fail <= 1'b1;
                  state <= S_FAIL;
`endif
               end else if (!all_lock) loss_cnt <= loss_cnt + LW'(1);
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sensor_link_ctrl.sv
// tb_sensor_link_ctrl: directed bench for the sensor link sequencer with small timing parameters.
module tb_sensor_link_ctrl;
   localparam int D = 4;
   localparam int SETTLE_CYC = 8;
   localparam int TRAIN_TIMEOUT = 32;
   localparam int LOSS_CYC = 16;
   localparam int MAX_RETRY = 2;
   localparam int BACKOFF_CYC = 16;
   logic px_clk = 1'b0, px_reset = 1'b1, enable = 1'b0, idelay_rdy = 1'b0;
   logic stream_req = 1'b0, sen_vs_in = 1'b0;
   logic [D-1:0] train_lock = '0, train_done = '0;
   logic train_start, stream_on_out, link_up, link_fail;
   logic [7:0] retry_cnt;
   logic [3:0] state_out;
   int errors = 0, checks = 0;
   always #5 px_clk = ~px_clk;
   sensor_link_ctrl #(
      .D(D), .SETTLE_CYC(SETTLE_CYC), .TRAIN_TIMEOUT(TRAIN_TIMEOUT), .LOSS_CYC(LOSS_CYC),
      .MAX_RETRY(MAX_RETRY), .BACKOFF_CYC(BACKOFF_CYC)
   ) dut (
      .px_clk(px_clk), .px_reset(px_reset), .enable(enable), .idelay_rdy(idelay_rdy),
      .stream_req(stream_req), .train_lock(train_lock), .train_done(train_done),
      .sen_vs_in(sen_vs_in), .train_start(train_start), .stream_on_out(stream_on_out),
      .link_up(link_up), .link_fail(link_fail), .retry_cnt(retry_cnt), .state_out(state_out)
   );
   task automatic tick;
      @(posedge px_clk);
      #1;
   endtask
   task automatic do_reset;
      px_reset = 1'b1; enable = 1'b0; idelay_rdy = 1'b0; stream_req = 1'b0; sen_vs_in = 1'b0;
      train_lock = '0; train_done = '0;
      tick; tick;
      px_reset = 1'b0;
   endtask
   task automatic wait_start(output int n);
      n = -1;
      for (int i = 1; i <= 200 && n < 0; i++) begin
         tick;
         if (train_start === 1'b1) n = i;
      end
   endtask
   task automatic bring_to_armed;
      do_reset;
      enable = 1'b1; idelay_rdy = 1'b1; train_done = '1; train_lock = '1;
      repeat (SETTLE_CYC + 5) tick;
   endtask
   task automatic test_reset;
      px_reset = 1'b1; enable = 1'b1; idelay_rdy = 1'b1;
      tick; tick;
      checks++; if (state_out !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_out); end
      checks++; if ({train_start, stream_on_out, link_up, link_fail, retry_cnt} !== 12'd0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 000", {train_start, stream_on_out, link_up, link_fail, retry_cnt}); end
   endtask
   task automatic test_nominal;
      int n;
      do_reset;
      enable = 1'b1; stream_req = 1'b1; sen_vs_in = 1'b1;
      repeat (5) tick;
      checks++; if (state_out !== 4'd1) begin errors++; $display("FAIL nom_wait_rdy: got %0d expected 1", state_out); end
      idelay_rdy = 1'b1;
      wait_start(n);
      checks++; if (n !== 9) begin errors++; $display("FAIL nom_start_delay: got %0d expected 9", n); end
      checks++; if (state_out !== 4'd3) begin errors++; $display("FAIL nom_start_state: got %0d expected 3", state_out); end
      tick;
      checks++; if (train_start !== 1'b0 || state_out !== 4'd4) begin
         errors++; $display("FAIL nom_pulse_once: got start=%b state=%0d expected 0/4", train_start, state_out); end
      repeat (18) tick;
      train_done = 4'hF; train_lock = 4'hF;
      tick; tick;
      checks++; if (state_out !== 4'd8 || stream_on_out !== 1'b0) begin
         errors++; $display("FAIL nom_armed: got state=%0d on=%b expected 8/0", state_out, stream_on_out); end
      n = 0;
      repeat (3) begin tick; if (stream_on_out !== 1'b0) n++; end
      checks++; if (n !== 0) begin errors++; $display("FAIL nom_wait_edge: got %0d early cycles expected 0", n); end
      sen_vs_in = 1'b0;
      tick;
      checks++; if (stream_on_out !== 1'b1 || link_up !== 1'b1 || state_out !== 4'd9) begin
         errors++; $display("FAIL nom_stream: got on=%b up=%b state=%0d expected 1/1/9", stream_on_out, link_up, state_out); end
   endtask
   task automatic test_frame_align;
      bring_to_armed;
      sen_vs_in = 1'b1; tick; sen_vs_in = 1'b0; tick; tick;
      checks++; if (state_out !== 4'd8 || stream_on_out !== 1'b0) begin
         errors++; $display("FAIL fa_no_req: got state=%0d on=%b expected 8/0", state_out, stream_on_out); end
      sen_vs_in = 1'b1; tick;
      stream_req = 1'b1; tick; tick;
      checks++; if (stream_on_out !== 1'b0) begin errors++; $display("FAIL fa_req_vs_high: got %b expected 0", stream_on_out); end
      sen_vs_in = 1'b0; tick;
      checks++; if (stream_on_out !== 1'b1) begin errors++; $display("FAIL fa_after_edge: got %b expected 1", stream_on_out); end
      stream_req = 1'b0; tick;
      checks++; if (stream_on_out !== 1'b0 || link_up !== 1'b0 || state_out !== 4'd8) begin
         errors++; $display("FAIL fa_req_drop: got on=%b up=%b state=%0d expected 0/0/8", stream_on_out, link_up, state_out); end
   endtask
   task automatic test_lock_glitch;
      int n;
      bring_to_armed;
      stream_req = 1'b1; sen_vs_in = 1'b1; tick; sen_vs_in = 1'b0; tick;
      checks++; if (state_out !== 4'd9) begin errors++; $display("FAIL lg_stream: got %0d expected 9", state_out); end
      train_lock = 4'hB;
      n = 0;
      repeat (LOSS_CYC - 1) begin tick; if (stream_on_out !== 1'b1) n++; end
      train_lock = 4'hF; tick;
      checks++; if (n !== 0 || stream_on_out !== 1'b1 || state_out !== 4'd9) begin
         errors++; $display("FAIL lg_short_glitch: got drops=%0d on=%b state=%0d expected 0/1/9", n, stream_on_out, state_out); end
      train_lock = 4'hB;
      repeat (LOSS_CYC) tick;
      train_lock = 4'hF;
      checks++; if (stream_on_out !== 1'b0 || link_up !== 1'b0) begin
         errors++; $display("FAIL lg_loss_drop: got on=%b up=%b expected 0/0", stream_on_out, link_up); end
`ifdef LINK_AUTO_RETRAIN_EN
      checks++; if (state_out !== 4'd7 || link_fail !== 1'b0 || retry_cnt !== 8'd0) begin
         errors++; $display("FAIL lg_retrain_state: got state=%0d fail=%b retry=%0d expected 7/0/0", state_out, link_fail, retry_cnt); end
      wait_start(n);
      checks++; if (n !== BACKOFF_CYC) begin errors++; $display("FAIL lg_retrain_start: got %0d expected %0d", n, BACKOFF_CYC); end
`else
      checks++; if (state_out !== 4'd10 || link_fail !== 1'b1) begin
         errors++; $display("FAIL lg_fail_state: got state=%0d fail=%b expected 10/1", state_out, link_fail); end
`endif
   endtask
   task automatic test_timeout;
      int n;
      do_reset;
      enable = 1'b1; idelay_rdy = 1'b1; train_done = 4'h7; train_lock = 4'hF;
      wait_start(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL to_first_start: got %0d expected 10", n); end
      wait_start(n);
      checks++; if (n !== 50 || retry_cnt !== 8'd1) begin
         errors++; $display("FAIL to_second_start: got gap=%0d retry=%0d expected 50/1", n, retry_cnt); end
      wait_start(n);
      checks++; if (n !== 50 || retry_cnt !== 8'd2) begin
         errors++; $display("FAIL to_third_start: got gap=%0d retry=%0d expected 50/2", n, retry_cnt); end
      n = 0;
      repeat (40) begin tick; if (train_start === 1'b1) n++; end
      checks++; if (n !== 0) begin errors++; $display("FAIL to_extra_start: got %0d pulses expected 0", n); end
      checks++; if (state_out !== 4'd10 || link_fail !== 1'b1 || retry_cnt !== 8'd2) begin
         errors++; $display("FAIL to_fail: got state=%0d fail=%b retry=%0d expected 10/1/2", state_out, link_fail, retry_cnt); end
      enable = 1'b0; tick;
      checks++; if (state_out !== 4'd0 || link_fail !== 1'b1 || retry_cnt !== 8'd0) begin
         errors++; $display("FAIL to_fail_exit: got state=%0d fail=%b retry=%0d expected 0/1/0", state_out, link_fail, retry_cnt); end
      enable = 1'b1;
      wait_start(n);
      checks++; if (n !== 10 || link_fail !== 1'b0) begin
         errors++; $display("FAIL to_restart: got gap=%0d fail=%b expected 10/0", n, link_fail); end
   endtask
   task automatic test_no_lock;
      int n;
      do_reset;
      enable = 1'b1; idelay_rdy = 1'b1; train_done = 4'hF; train_lock = 4'hE;
      wait_start(n);
      tick; tick;
      checks++; if (state_out !== 4'd5) begin errors++; $display("FAIL nl_check: got %0d expected 5", state_out); end
      tick;
      checks++; if (state_out !== 4'd6) begin errors++; $display("FAIL nl_retry: got %0d expected 6", state_out); end
      tick;
      checks++; if (state_out !== 4'd7 || retry_cnt !== 8'd1) begin
         errors++; $display("FAIL nl_backoff: got state=%0d retry=%0d expected 7/1", state_out, retry_cnt); end
      wait_start(n);
      checks++; if (n !== BACKOFF_CYC) begin errors++; $display("FAIL nl_restart: got %0d expected %0d", n, BACKOFF_CYC); end
   endtask
   task automatic test_abort;
      int n;
      do_reset;
      enable = 1'b1; idelay_rdy = 1'b1;
      repeat (SETTLE_CYC + 1) tick;
      checks++; if (state_out !== 4'd2) begin errors++; $display("FAIL ab_settle: got %0d expected 2", state_out); end
      px_reset = 1'b1; tick;
      checks++; if (train_start !== 1'b0 || state_out !== 4'd0) begin
         errors++; $display("FAIL ab_reset_no_start: got start=%b state=%0d expected 0/0", train_start, state_out); end
      px_reset = 1'b0;
      wait_start(n);
      tick; tick; tick;
      checks++; if (n !== 10 || state_out !== 4'd4) begin
         errors++; $display("FAIL ab_reach_train: got gap=%0d state=%0d expected 10/4", n, state_out); end
      px_reset = 1'b1; tick;
      checks++; if ({train_start, stream_on_out, link_up, link_fail, retry_cnt, state_out} !== 16'd0) begin
         errors++; $display("FAIL ab_reset_train: got %h expected 0000", {train_start, stream_on_out, link_up, link_fail, retry_cnt, state_out}); end
      px_reset = 1'b0;
      wait_start(n);
      tick;
      enable = 1'b0; tick;
      checks++; if ({train_start, stream_on_out, link_up, link_fail, retry_cnt, state_out} !== 16'd0) begin
         errors++; $display("FAIL ab_disable_train: got %h expected 0000", {train_start, stream_on_out, link_up, link_fail, retry_cnt, state_out}); end
      enable = 1'b1;
      wait_start(n);
      tick;
      idelay_rdy = 1'b0; tick;
      checks++; if (state_out !== 4'd0) begin errors++; $display("FAIL ab_idelay_drop: got %0d expected 0", state_out); end
      idelay_rdy = 1'b1; tick;
      checks++; if (state_out !== 4'd1) begin errors++; $display("FAIL ab_idelay_rewait: got %0d expected 1", state_out); end
   endtask
   initial begin
      test_reset;
      test_nominal;
      test_frame_align;
      test_lock_glitch;
      test_timeout;
      test_no_lock;
      test_abort;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
